// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default sizes for the data-memory arbiter.
//   owner_t     : which requester the in-flight read belongs to
//   arb_state_t : arbitration priority state
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W       = 19;
    localparam int unsigned DMEM_DATA_W       = 32;
    localparam int unsigned DMEM_AUX_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_AUX
    } owner_t;

    typedef enum logic {
        S_CPU_PRI,
        S_AUX_PRI
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive cycles the aux requester was denied.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_inc   : aux requested and was denied this cycle
//   i_clr   : aux granted, idle, or priority handed to aux (clear wins over inc)
//   o_hit   : this denial brings the count to AUX_MAX_WAIT
module arb_starve_counter #(
    parameter int unsigned AUX_MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int unsigned CNT_W = $clog2(AUX_MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The threshold is hit by the denial itself, so priority flips on the next cycle.
    assign o_hit = i_inc && !i_clr && (r_cnt == CNT_W'(AUX_MAX_WAIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the
// pipeline M-stage (read/write) and an auxiliary read-only requester.
// Optional feature macro: DMEM_ARB_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata          : M-stage access request (held while stalled)
//   cpu_stall                      : CPU lost arbitration this cycle
//   cpu_rvalid/rdata               : CPU load data, one cycle after grant
//   aux_req/addr, aux_gnt          : aux read request and its acceptance
//   aux_rvalid/rdata               : aux read data, one cycle after grant
//   perf_stall_cnt/perf_aux_cnt    : stall cycles / aux grants (macro only)
//   mem_en/we/addr/wdata, mem_rdata: memory port, 1-cycle read latency
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DMEM_ADDR_W,
    parameter int unsigned DATA_W       = DMEM_DATA_W,
    parameter int unsigned AUX_MAX_WAIT = DMEM_AUX_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_aux_cnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    owner_t            r_rsel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_cpu_gnt;
    logic w_aux_gnt;
    logic w_aux_denied;
    logic w_hit;

    // Grants are gated by reset so nothing reaches memory while rst is low.
    assign w_aux_gnt    = rst && aux_req && ((r_state == S_AUX_PRI) || !cpu_req);
    assign w_cpu_gnt    = rst && cpu_req && !w_aux_gnt;
    assign w_aux_denied = rst && aux_req && !w_aux_gnt;

    arb_starve_counter #(
        .AUX_MAX_WAIT (AUX_MAX_WAIT)
    ) u_starve (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_aux_denied),
        .i_clr   (!w_aux_denied),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_CPU_PRI;
            r_rsel  <= OWN_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            // Aux priority lasts exactly one cycle.
            r_state <= ((r_state == S_CPU_PRI) && w_hit) ? S_AUX_PRI : S_CPU_PRI;

            if (w_cpu_gnt && !cpu_we) begin
                r_rsel <= OWN_CPU;
            end else if (w_aux_gnt) begin
                r_rsel <= OWN_AUX;
            end else begin
                r_rsel <= OWN_NONE;
            end

            if (w_cpu_gnt) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end else if (w_aux_gnt) begin
                r_addr  <= aux_addr;
            end
        end
    end

    assign cpu_stall = rst && cpu_req && !w_cpu_gnt;
    assign aux_gnt   = w_aux_gnt;

    assign mem_en    = w_cpu_gnt || w_aux_gnt;
    assign mem_we    = w_cpu_gnt && cpu_we;
    assign mem_addr  = w_cpu_gnt ? cpu_addr : (w_aux_gnt ? aux_addr : r_addr);
    assign mem_wdata = w_cpu_gnt ? cpu_wdata : r_wdata;

    // Gating with rst drops a read that was in flight when reset arrived.
    assign cpu_rvalid = rst && (r_rsel == OWN_CPU);
    assign aux_rvalid = rst && (r_rsel == OWN_AUX);
    assign cpu_rdata  = mem_rdata;
    assign aux_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_aux;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_aux   <= '0;
        end else begin
            if (cpu_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_aux_gnt && (r_perf_aux != '1)) begin
                r_perf_aux <= r_perf_aux + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_aux_cnt   = r_perf_aux;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: bench for dmem_arbiter with a behavioural memory and a
// reference arbitration model driven by randomized traffic.
module tb_dmem_arbiter;

    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          aux_req, aux_gnt, aux_rvalid;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_aux_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0] mem_arr [0:1023];
    logic [DW-1:0] exp_mem [0:1023];
    bit            mem_init = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .AUX_MAX_WAIT (MAXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata),
`ifdef DMEM_ARB_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_aux_cnt   (perf_aux_cnt),
`endif
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous memory, 1-cycle read latency, pattern-filled.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'hC0DE_0000 ^ (i * 32'h0001_0003);
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr[9:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        aux_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; aux_req = 1'b1;
        #2;
        checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        checks++; if (aux_gnt !== 1'b0) begin errs++; $display("FAIL reset_aux_gnt: got %b want 0", aux_gnt); end
        checks++; if (mem_en !== 1'b0) begin errs++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
        checks++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL reset_aux_rvalid: got %b want 0", aux_rvalid); end
        step();
        rst = 1'b1; idle();
        step();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 32'hDEAD_BEEF;
        #2;
        checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL st_stall: got %b want 0", cpu_stall); end
        checks++; if ({mem_en, mem_we} !== 2'b11) begin errs++; $display("FAIL st_en_we: got %b want 11", {mem_en, mem_we}); end
        checks++; if (mem_addr !== 19'h00010 || mem_wdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL st_bus: got %h/%h want 00010/deadbeef", mem_addr, mem_wdata); end
        step();
        cpu_we = 1'b0;
        #2;
        checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL ld_stall: got %b want 0", cpu_stall); end
        checks++; if ({mem_en, mem_we} !== 2'b10) begin errs++; $display("FAIL ld_en_we: got %b want 10", {mem_en, mem_we}); end
        checks++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL st_no_rvalid: got %b want 0", cpu_rvalid); end
        step();
        idle();
        #2;
        checks++; if (cpu_rvalid !== 1'b1) begin errs++; $display("FAIL ld_rvalid: got %b want 1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ld_rdata: got %h want deadbeef", cpu_rdata); end
        checks++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL ld_aux_rvalid: got %b want 0", aux_rvalid); end
        step();
    endtask

    task automatic test_contention();
        bit ea;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
        aux_req = 1'b1; aux_addr = 19'h00030;
        for (int k = 1; k <= 27; k++) begin
            #2;
            ea = (k % 9 == 0);
            checks++; if (aux_gnt !== ea) begin errs++; $display("FAIL cont_aux_gnt[%0d]: got %b want %b", k, aux_gnt, ea); end
            checks++; if (cpu_stall !== ea) begin errs++; $display("FAIL cont_stall[%0d]: got %b want %b", k, cpu_stall, ea); end
            checks++; if (mem_addr !== (ea ? 19'h00030 : 19'h00020)) begin
                errs++; $display("FAIL cont_addr[%0d]: got %h want %h", k, mem_addr, ea ? 19'h00030 : 19'h00020); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_aux_burst();
        logic [DW-1:0] prev;
        prev = '0;
        for (int i = 0; i < 16; i++) begin
            aux_req = 1'b1; aux_addr = AW'(i);
            #2;
            checks++; if (aux_gnt !== 1'b1) begin errs++; $display("FAIL burst_gnt[%0d]: got %b want 1", i, aux_gnt); end
            if (i > 0) begin
                checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== prev) begin
                    errs++; $display("FAIL burst_data[%0d]: got %b/%h want 1/%h", i, aux_rvalid, aux_rdata, prev); end
            end
            checks++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL burst_cpu_rvalid[%0d]: got %b want 0", i, cpu_rvalid); end
            prev = mem_arr[i];
            step();
        end
        idle();
        #2;
        checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== prev) begin
            errs++; $display("FAIL burst_last: got %b/%h want 1/%h", aux_rvalid, aux_rdata, prev); end
        step();
    endtask

    task automatic test_interleave();
        logic [DW-1:0] exp_aux;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        #2;
        checks++; if (mem_en !== 1'b1 || cpu_stall !== 1'b0) begin
            errs++; $display("FAIL il_cpu_gnt: got en=%b stall=%b want 1/0", mem_en, cpu_stall); end
        step();
        cpu_req = 1'b0; aux_req = 1'b1; aux_addr = 19'h00005;
        exp_aux = mem_arr[5];
        #2;
        checks++; if (aux_gnt !== 1'b1) begin errs++; $display("FAIL il_aux_gnt: got %b want 1", aux_gnt); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL il_cpu_ret: got %b/%h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
        checks++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL il_aux_early: got %b want 0", aux_rvalid); end
        step();
        idle();
        #2;
        checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_aux) begin
            errs++; $display("FAIL il_aux_ret: got %b/%h want 1/%h", aux_rvalid, aux_rdata, exp_aux); end
        checks++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL il_cpu_late: got %b want 0", cpu_rvalid); end
        step();
    endtask

    task automatic test_reset_mid_read();
        bit ea;
        aux_req = 1'b1; aux_addr = 19'h00007;
        #2;
        checks++; if (aux_gnt !== 1'b1) begin errs++; $display("FAIL rmr_gnt: got %b want 1", aux_gnt); end
        step();
        rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            checks++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL rmr_rvalid[%0d]: got %b want 0", k, aux_rvalid); end
            checks++; if ({aux_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid} !== 5'b0) begin
                errs++; $display("FAIL rmr_outs[%0d]: got %b want 00000", k, {aux_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid}); end
            step();
        end
        rst = 1'b1; idle();
        #2;
        checks++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL rmr_after: got %b want 0", aux_rvalid); end
        step();
        // Build up partial starvation, reset, then the full wait must be served again.
        cpu_req = 1'b1; cpu_we = 1'b0; aux_req = 1'b1;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #2;
            ea = (k == 9);
            checks++; if (aux_gnt !== ea) begin errs++; $display("FAIL rmr_wait[%0d]: got %b want %b", k, aux_gnt, ea); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_random();
        bit            m_force, ea, ec;
        int            m_wait, pend;
        logic [DW-1:0] pend_data;
        do_reset();
        for (int i = 0; i < 1024; i++) exp_mem[i] = mem_arr[i];
        m_force = 1'b0; m_wait = 0; pend = 0; pend_data = '0;
        for (int n = 0; n < 600; n++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            aux_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = AW'($urandom_range(0, 63));
            aux_addr  = AW'($urandom_range(0, 63));
            cpu_wdata = $urandom();
            #2;
            ea = aux_req && (m_force || !cpu_req);
            ec = cpu_req && !ea;
            checks++; if (aux_gnt !== ea) begin errs++; $display("FAIL rnd_aux_gnt[%0d]: got %b want %b", n, aux_gnt, ea); end
            checks++; if (cpu_stall !== (cpu_req && !ec)) begin
                errs++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, cpu_stall, cpu_req && !ec); end
            checks++; if ({mem_en, mem_we} !== {ea || ec, ec && cpu_we}) begin
                errs++; $display("FAIL rnd_en_we[%0d]: got %b want %b", n, {mem_en, mem_we}, {ea || ec, ec && cpu_we}); end
            if (ec || ea) begin
                checks++; if (mem_addr !== (ec ? cpu_addr : aux_addr)) begin
                    errs++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, mem_addr, ec ? cpu_addr : aux_addr); end
            end
            if (ec && cpu_we) begin
                checks++; if (mem_wdata !== cpu_wdata) begin
                    errs++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, mem_wdata, cpu_wdata); end
            end
            checks++; if ({cpu_rvalid, aux_rvalid} !== {pend == 1, pend == 2}) begin
                errs++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, {cpu_rvalid, aux_rvalid}, {pend == 1, pend == 2}); end
            if (pend == 1) begin
                checks++; if (cpu_rdata !== pend_data) begin
                    errs++; $display("FAIL rnd_cpu_rdata[%0d]: got %h want %h", n, cpu_rdata, pend_data); end
            end else if (pend == 2) begin
                checks++; if (aux_rdata !== pend_data) begin
                    errs++; $display("FAIL rnd_aux_rdata[%0d]: got %h want %h", n, aux_rdata, pend_data); end
            end
            if (ec && !cpu_we) begin
                pend = 1; pend_data = exp_mem[cpu_addr[9:0]];
            end else if (ea) begin
                pend = 2; pend_data = exp_mem[aux_addr[9:0]];
            end else begin
                pend = 0;
            end
            if (ec && cpu_we) exp_mem[cpu_addr[9:0]] = cpu_wdata;
            if (m_force) begin
                m_force = 1'b0; m_wait = 0;
            end else if (aux_req && !ea) begin
                m_wait++;
                if (m_wait == MAXW) m_force = 1'b1;
            end else begin
                m_wait = 0;
            end
            step();
        end
        idle();
        step();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
        aux_req = 1'b1; aux_addr = 19'h00030;
        for (int k = 0; k < 18; k++) step();
        idle();
        #2;
        checks++; if (perf_stall_cnt !== 32'd2) begin errs++; $display("FAIL perf_stall: got %0d want 2", perf_stall_cnt); end
        checks++; if (perf_aux_cnt !== 32'd2) begin errs++; $display("FAIL perf_aux: got %0d want 2", perf_aux_cnt); end
        step();
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle();
        cpu_addr = '0; cpu_wdata = '0; aux_addr = '0;
        step(); step(); step();
        rst = 1'b1;
        step();
        test_reset();
        test_cpu_only();
        test_contention();
        test_aux_burst();
        test_interleave();
        test_reset_mid_read();
        test_random();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the pipeline memory stage (CPU port: address from the M-stage ALU result, store data from the M-stage write data) and an auxiliary read-only requester (image readout / display engine).
- Arbitrates one access per cycle.
- Stalls the pipeline when the CPU loses arbitration.
- Routes 1-cycle-latency read data back to the correct owner.
- An anti-starvation counter guarantees the auxiliary port bounded service.

Parameters:
ADDR_W, 19, memory address width (matches M-stage ALU result width)
DATA_W, 32, memory data width
AUX_MAX_WAIT, 8, max consecutive denied cycles for aux before forced grant (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
cpu_req  in  1  M-stage memory access request (load or store)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  M-stage address
cpu_wdata  in  DATA_W  store data
cpu_stall  out  1  hold IF/ID/EX/M registers this cycle
cpu_rvalid  out  1  load data valid (cycle after CPU grant)
cpu_rdata  out  DATA_W  load data
aux_req  in  1  aux read request
aux_addr  in  ADDR_W  aux read address
aux_gnt  out  1  aux request accepted this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  DATA_W  aux read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en & !mem_we

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-low.
- While rst == 0:
  - all grants 0, cpu_stall = 0, mem_en = 0, mem_we = 0;
  - cpu_rvalid = aux_rvalid = 0; wait_cnt = 0; state = S_CPU_PRI; rsel = OWN_NONE.
  - A read in flight when reset asserts is discarded; no rvalid follows.
- FSM, state S_CPU_PRI:
  - cpu_req wins; aux granted only if !cpu_req.
  - wait_cnt increments each cycle aux_req=1 and aux is denied; clears on aux grant or aux_req=0.
  - When a denial makes wait_cnt reach AUX_MAX_WAIT, next state = S_AUX_PRI.
- FSM, state S_AUX_PRI:
  - aux wins if aux_req, else CPU served normally.
  - Always returns to S_CPU_PRI next cycle; wait_cnt cleared.
- Grant logic (combinational from state and requests):
  - cpu_gnt = cpu_req & winner_is_cpu.
  - cpu_stall = cpu_req & !cpu_gnt.
  - aux_gnt = aux_req & winner_is_aux.
- Memory drive (combinational):
  - mem_en = cpu_gnt | aux_gnt.
  - mem_we = cpu_gnt & cpu_we; aux never writes.
  - mem_addr/mem_wdata from winner; when idle, hold the last value (don't-care, no toggling required).
- Read return:
  - rsel registered as OWN_CPU on a CPU load grant, OWN_AUX on an aux grant, else OWN_NONE.
  - Next cycle: cpu_rvalid = (rsel == OWN_CPU), aux_rvalid = (rsel == OWN_AUX).
  - cpu_rdata/aux_rdata = mem_rdata (qualified by rvalid).
  - CPU store grants produce no rvalid.
- Stalled CPU request: CPU holds cpu_req/we/addr/wdata stable; arbiter does not latch them.
- Simultaneous aux grant and return of previous CPU read: both occur same cycle, no conflict.
- Aux may deassert aux_req after denial; no penalty, wait_cnt clears.
- Back-to-back accesses: full throughput, one grant per cycle.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds outputs perf_stall_cnt [31:0] (cycles with cpu_stall=1) and perf_aux_cnt [31:0] (aux grants). Both are saturating and reset to 0.
- Undefined: ports and counters absent; identical arbitration behaviour.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum owner_t {OWN_NONE, OWN_CPU, OWN_AUX};
  - typedef enum arb_state_t {S_CPU_PRI, S_AUX_PRI};
  - localparam defaults for ADDR_W/DATA_W.
- One sub-module, arb_starve_counter:
  - wait_cnt with increment/clear/threshold-hit output, parameter AUX_MAX_WAIT;
  - width $clog2(AUX_MAX_WAIT+1).

Test Plan:
- CPU-only traffic:
  - Stimulus: store 0xDEADBEEF to 0x00010, then load from 0x00010.
  - Response: cpu_stall never 1; mem_we=1 on the store cycle; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle after the load grant.
- Contention:
  - Stimulus: cpu_req and aux_req both held, AUX_MAX_WAIT=8.
  - Response: CPU granted 8 cycles; cycle 9 aux_gnt=1 with cpu_stall=1; CPU resumes cycle 10; pattern repeats every 9 cycles.
- Aux-only burst:
  - Stimulus: aux reads addresses 0..15.
  - Response: aux_gnt every cycle; aux_rvalid stream with rdata matching the memory model, 1-cycle lag.
- Interleave routing:
  - Stimulus: CPU load at cycle N, aux grant at cycle N+1.
  - Response: cpu_rvalid at N+1 only, aux_rvalid at N+2 only, data not swapped.
- Reset mid-read:
  - Stimulus: rst=0 on the cycle after an aux read grant.
  - Response: aux_rvalid stays 0; all outputs at reset values; wait_cnt=0 after release.
- DMEM_ARB_PERF_EN:
  - Stimulus: contention scenario for 18 cycles.
  - Response: perf_stall_cnt=2, perf_aux_cnt=2.
